pwm_multi_ctrl: RTL and testbench
=================================

# pwm_multi_ctrl

Multi-channel, parametrised PWM generator for motor ESC drive. It is the successor to the single-channel period/duty comparator. All channels share one period counter. Each channel has its own duty compare. Period and duty values written by the processor side are double-buffered and applied only at a period boundary, so no glitch pulses occur. A latching stop input forces every output low until software explicitly clears it. The block sits between the Nios II PIO registers (period, duty, control) and the motor PWM pins.

## Interface

Parameters:
- `CH`, 4, number of PWM channels (1..16)
- `W`, 28, counter/period/duty width in bits (8..32)

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `period_in`  in  W  requested period value; actual period is period_in+1 clocks
- `duty_in`  in  CH*W  requested duty per channel; channel i uses bits [i*W +: W]; high time in clocks
- `load`  in  1  single-cycle strobe; captures period_in/duty_in into shadow registers
- `enable`  in  1  level; run PWM when high
- `stop`  in  1  emergency stop; level-sensitive, latched internally
- `clear`  in  1  single-cycle strobe; releases the latched stop
- `pwm_out`  out  CH  registered PWM outputs
- `period_start`  out  1  one-cycle pulse when the counter is 0 in RUN
- `pending`  out  1  shadow holds values not yet applied
- `state`  out  2  00 IDLE, 01 RUN, 10 FAULT

## Operation

- Registers:
  - counter (W bits)
  - period_act, duty_act[CH] (active)
  - period_sh, duty_sh[CH] (shadow)
  - pending flag
  - 2-bit state
- Reset values:
  - all registers 0
  - state = IDLE
  - pwm_out = 0, period_start = 0, pending = 0
- State machine, priority stop > clear > enable:
  - any state -> FAULT when stop = 1
  - FAULT -> IDLE when stop = 0 and clear = 1; FAULT holds while stop = 1, even if clear = 1
  - IDLE -> RUN when enable = 1
  - RUN -> IDLE when enable = 0
- IDLE and FAULT:
  - counter held at 0, pwm_out = 0
  - active registers copy shadow every cycle; pending cleared
  - RUN therefore always starts with the latest loaded values
- RUN:
  - wrap = (counter >= period_act)
  - on wrap, counter <= 0, else counter <= counter+1
  - on wrap, active <= shadow and pending <= 0
- load:
  - shadow <= inputs; pending <= 1
  - If load coincides with wrap, the freshly loaded inputs go directly to the active registers and pending stays 0.
- Compare: pwm_out[i] <= (state==RUN) && (counter < duty_act[i]).
  - duty = 0 gives constant low.
  - duty > period_act gives constant high.
- period_act = 0: wrap occurs every cycle, counter stays 0, period_start stays high continuously.
- Arithmetic is unsigned, W bits. Counter never exceeds period_act, so no overflow is possible.

## Timing

- pwm_out lags the counter value it reflects by 1 clock. The first high output appears 1 clock after entering RUN.
- Shadow-to-active transfer takes effect on the counter==0 cycle of the next period. The output follows 1 clock later.
- stop sampled high -> state = FAULT and pwm_out = 0 on the next rising edge (1-clock latency), mid-period included.
- enable low -> pwm_out = 0 on the next edge; the partial period is discarded.
- reset_n low asynchronously clears everything, mid-period included. The deassertion edge is synchronised externally.
- period_start is registered alongside pwm_out, so both are aligned.

## Test plan

- Reset, then load period_in=9, duty ch0..3 = 0,3,10,5, then enable=1:
  - ch0 constant low
  - ch1 high 3 of every 10 clocks
  - ch2 constant high
  - ch3 high 5 of every 10 clocks
  - period_start every 10 clocks
- Mid-period load of ch1 duty=7:
  - pending=1 until the next wrap
  - the current period keeps 3 high clocks; the next period has 7
  - no runt pulse
- load asserted in the same cycle as wrap: new duty is active for the period starting at the following counter==0 cycle, and pending is never raised.
- stop pulse mid-period:
  - all pwm_out = 0 next clock, state = FAULT
  - enable=1 and clear while stop=1 have no effect
  - clear after stop=0 -> IDLE, then RUN restarts from counter 0
- period_in=0, duty=1: pwm_out constant high and period_start constant high in RUN. Then duty=0 applied -> constant low.
- Assert reset_n low mid-period with CH=1, W=8: outputs 0 immediately and state IDLE. After release with enable held, operation restarts using the zeroed registers (all outputs low).

Source files
------------

// File: rtl/pwm_multi_ctrl_if.sv
// Processor-side register bus and PWM pin bundle for pwm_multi_ctrl.
interface pwm_multi_ctrl_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 28
);
  logic [W-1:0]    period_in;
  logic [CH*W-1:0] duty_in;
  logic            load;
  logic            enable;
  logic            stop;
  logic            clear;
  logic [CH-1:0]   pwm_out;
  logic            period_start;
  logic            pending;
  logic [1:0]      state;

  modport master (
    output period_in, duty_in, load, enable, stop, clear,
    input  pwm_out, period_start, pending, state
  );

  modport slave (
    input  period_in, duty_in, load, enable, stop, clear,
    output pwm_out, period_start, pending, state
  );
endinterface

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: shared period counter, per-channel duty compare,
// double-buffered period/duty applied at period boundaries, latching stop.
module pwm_multi_ctrl #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 28
) (
  input  logic            clk,
  input  logic            reset_n,
  pwm_multi_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           counter_q, counter_d;
  logic [W-1:0]           period_act_q, period_act_d;
  logic [W-1:0]           period_sh_q, period_sh_d;
  logic [CH-1:0][W-1:0]   duty_act_q, duty_act_d;
  logic [CH-1:0][W-1:0]   duty_sh_q, duty_sh_d;
  logic [CH-1:0][W-1:0]   duty_in_w;
  logic                   pending_q, pending_d;
  logic [CH-1:0]          pwm_q, pwm_d;
  logic                   period_start_q, period_start_d;
  logic                   run_now;
  logic                   wrap;

  assign duty_in_w = bus.duty_in;

  always_comb begin : fsm_next
    state_d = state_q;
    if (bus.stop) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE:    if (bus.enable) state_d = RUN;
        RUN:     if (!bus.enable) state_d = IDLE;
        FAULT:   if (bus.clear) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and counting are gated by staying in RUN across the edge, so stop
  // and enable-low blank the pins on the very next edge.
  always_comb begin : datapath
    run_now        = (state_q == RUN) && (state_d == RUN);
    wrap           = (counter_q >= period_act_q);
    counter_d      = '0;
    period_act_d   = period_act_q;
    duty_act_d     = duty_act_q;
    period_sh_d    = period_sh_q;
    duty_sh_d      = duty_sh_q;
    pending_d      = pending_q;

    if (bus.load) begin
      period_sh_d = bus.period_in;
      duty_sh_d   = duty_in_w;
    end

    // Transfer reads the post-load shadow, so a load on the wrap cycle goes
    // straight to the active set without ever raising pending.
    if (!run_now || wrap) begin
      period_act_d = period_sh_d;
      duty_act_d   = duty_sh_d;
      pending_d    = 1'b0;
    end else begin
      counter_d = counter_q + W'(1);
      if (bus.load) pending_d = 1'b1;
    end

    period_start_d = run_now && (counter_q == '0);
    pwm_d          = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      pwm_d[i] = run_now && (counter_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      period_act_q   <= '0;
      period_sh_q    <= '0;
      duty_act_q     <= '0;
      duty_sh_q      <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      period_act_q   <= period_act_d;
      period_sh_q    <= period_sh_d;
      duty_act_q     <= duty_act_d;
      duty_sh_q      <= duty_sh_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.pending      = pending_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl: table vectors, corner sequences,
// randomized run against a behavioural model; second small instance for reset.
module tb_pwm_multi_ctrl;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 28;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic clk;
  logic reset_n;
  logic reset_n2;

  pwm_multi_ctrl_if #(.CH(CH), .W(W)) b1 ();
  pwm_multi_ctrl_if #(.CH(1),  .W(8)) b2 ();

  pwm_multi_ctrl #(.CH(CH), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b1)
  );

  pwm_multi_ctrl #(.CH(1), .W(8)) dut_small (
    .clk     (clk),
    .reset_n (reset_n2),
    .bus     (b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, position within the period, active/shadow sets.
  int          m_mode;
  int unsigned m_cnt;
  int unsigned m_per_act, m_per_sh;
  int unsigned m_duty_act[CH];
  int unsigned m_duty_sh[CH];
  bit          m_pending;
  logic [CH-1:0] exp_pwm;
  logic          exp_ps;

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_per_act = 0; m_per_sh = 0; m_pending = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty_act[i] = 0;
      m_duty_sh[i]  = 0;
    end
  endtask

  task automatic model_step();
    int nxt;
    bit run;
    if (b1.stop)                nxt = M_FAULT;
    else if (m_mode == M_FAULT) nxt = b1.clear ? M_IDLE : M_FAULT;
    else                        nxt = b1.enable ? M_RUN : M_IDLE;
    run    = (m_mode == M_RUN) && (nxt == M_RUN);
    exp_ps = run && (m_cnt == 0);
    for (int i = 0; i < CH; i++) exp_pwm[i] = run && (m_cnt < m_duty_act[i]);
    if (b1.load) begin
      m_per_sh = b1.period_in;
      for (int i = 0; i < CH; i++) m_duty_sh[i] = b1.duty_in[i*W +: W];
    end
    if (run && m_cnt < m_per_act) begin
      m_cnt++;
      if (b1.load) m_pending = 1;
    end else begin
      m_cnt      = 0;
      m_per_act  = m_per_sh;
      m_duty_act = m_duty_sh;
      m_pending  = 0;
    end
    m_mode = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_pwm_out", b1.pwm_out, exp_pwm);
    chk("model_period_start", b1.period_start, exp_ps);
    chk("model_pending", b1.pending, m_pending);
    chk("model_state", b1.state, m_mode);
  endtask

  task automatic set_duties(input int unsigned d0, input int unsigned d1,
                            input int unsigned d2, input int unsigned d3);
    b1.duty_in[0*W +: W] = W'(d0);
    b1.duty_in[1*W +: W] = W'(d1);
    b1.duty_in[2*W +: W] = W'(d2);
    b1.duty_in[3*W +: W] = W'(d3);
  endtask

  task automatic start_run(input int unsigned per, input int unsigned d0, input int unsigned d1,
                           input int unsigned d2, input int unsigned d3);
    b1.enable = 0; tick();
    b1.period_in = W'(per);
    set_duties(d0, d1, d2, d3);
    b1.load = 1; tick();
    b1.load = 0;
    b1.enable = 1; tick();
  endtask

  task automatic wait_cnt(input int unsigned target);
    for (int k = 0; k < 40 && m_cnt != target; k++) tick();
    chk("wait_counter_reached", m_cnt, target);
  endtask

  typedef struct {
    int unsigned       per;
    logic [3:0][7:0]   duty;
    logic [3:0][7:0]   hi;
    int unsigned       ps;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hi[CH];
    int unsigned ps;
    int unsigned runt, newhi;
    logic [3:0] bits4;

    // {per, duty ch3..ch0, expected high clocks ch3..ch0 over 20 clocks, period_start count}
    tbl[0] = '{9, {8'd5, 8'd10, 8'd3, 8'd0}, {8'd10, 8'd20, 8'd6, 8'd0}, 2};
    tbl[1] = '{0, {8'd0, 8'd5, 8'd0, 8'd1},  {8'd0, 8'd20, 8'd0, 8'd20}, 20};
    tbl[2] = '{4, {8'd2, 8'd1, 8'd5, 8'd4},  {8'd8, 8'd4, 8'd20, 8'd16}, 4};
    tbl[3] = '{1, {8'd3, 8'd0, 8'd2, 8'd1},  {8'd20, 8'd0, 8'd20, 8'd10}, 10};

    reset_n = 0; reset_n2 = 0;
    b1.period_in = '0; b1.duty_in = '0; b1.load = 0; b1.enable = 0; b1.stop = 0; b1.clear = 0;
    b2.period_in = '0; b2.duty_in = '0; b2.load = 0; b2.enable = 0; b2.stop = 0; b2.clear = 0;
    model_reset();
    #12;
    chk("reset_pwm_out", b1.pwm_out, 0);
    chk("reset_period_start", b1.period_start, 0);
    chk("reset_pending", b1.pending, 0);
    chk("reset_state", b1.state, 0);
    reset_n = 1; reset_n2 = 1;

    for (int v = 0; v < 4; v++) begin
      start_run(tbl[v].per, tbl[v].duty[0], tbl[v].duty[1], tbl[v].duty[2], tbl[v].duty[3]);
      for (int c = 0; c < CH; c++) hi[c] = 0;
      ps = 0;
      repeat (20) begin
        tick();
        for (int c = 0; c < CH; c++) if (b1.pwm_out[c]) hi[c]++;
        if (b1.period_start) ps++;
      end
      for (int c = 0; c < CH; c++)
        chk($sformatf("tbl%0d_high_ch%0d", v, c), hi[c], tbl[v].hi[c]);
      chk($sformatf("tbl%0d_period_starts", v), ps, tbl[v].ps);
    end

    // Mid-period load of ch1 duty 7: no runt, pending until the wrap.
    start_run(9, 0, 3, 10, 5);
    wait_cnt(5);
    set_duties(0, 7, 10, 5);
    b1.load = 1; tick(); b1.load = 0;
    chk("midload_pending_set", b1.pending, 1);
    runt = 0; newhi = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t <= 4) runt += b1.pwm_out[1];
      else        newhi += b1.pwm_out[1];
      if (t == 3) chk("midload_pending_held", b1.pending, 1);
      if (t == 4) chk("midload_pending_cleared", b1.pending, 0);
    end
    chk("midload_no_runt", runt, 0);
    chk("midload_new_high", newhi, 7);

    // Load on the wrap cycle: applied next period, pending never raised.
    wait_cnt(9);
    set_duties(0, 7, 10, 2);
    b1.load = 1; tick(); b1.load = 0;
    chk("wrapload_pending", b1.pending, 0);
    tick();
    chk("wrapload_ch3_t1", b1.pwm_out[3], 1);
    chk("wrapload_pending_t1", b1.pending, 0);
    tick(); tick();
    chk("wrapload_ch3_t3", b1.pwm_out[3], 0);

    // Zero period: constant high, then duty 0 gives constant low.
    start_run(0, 1, 1, 1, 1);
    tick(); tick();
    chk("per0_pwm_high", b1.pwm_out, 4'hf);
    chk("per0_period_start", b1.period_start, 1);
    set_duties(0, 0, 0, 0);
    b1.load = 1; tick(); b1.load = 0;
    tick();
    chk("per0_duty0_low", b1.pwm_out, 4'h0);
    chk("per0_duty0_ps", b1.period_start, 1);
    chk("per0_duty0_pending", b1.pending, 0);

    // Stop mid-period, clear blocked while stop held, restart from counter 0.
    start_run(9, 0, 3, 10, 5);
    wait_cnt(4);
    b1.stop = 1; tick();
    chk("stop_state_fault", b1.state, 2);
    chk("stop_pwm_low", b1.pwm_out, 4'h0);
    b1.enable = 1; b1.clear = 1; tick();
    chk("stop_clear_blocked", b1.state, 2);
    b1.stop = 0; tick();
    chk("clear_to_idle", b1.state, 0);
    b1.clear = 0; tick();
    chk("restart_run", b1.state, 1);
    tick();
    chk("restart_period_start", b1.period_start, 1);
    bits4 = b1.pwm_out;
    chk("restart_pwm", bits4, 4'b1110);
    b1.enable = 0; tick();

    // Asynchronous reset mid-period on the CH=1, W=8 instance.
    b2.period_in = 8'd9; b2.duty_in = 8'd5; b2.load = 1; tick();
    b2.load = 0; b2.enable = 1; tick();
    tick(); tick(); tick();
    chk("small_pre_pwm", b2.pwm_out, 1);
    chk("small_pre_state", b2.state, 1);
    #3;
    reset_n2 = 0;
    #1;
    chk("small_async_pwm", b2.pwm_out, 0);
    chk("small_async_state", b2.state, 0);
    chk("small_async_ps", b2.period_start, 0);
    tick();
    chk("small_held_state", b2.state, 0);
    reset_n2 = 1;
    tick();
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("small_zeroed_pwm", b2.pwm_out, 0);
      chk("small_zeroed_state", b2.state, 1);
      chk("small_zeroed_ps", b2.period_start, 1);
    end

    // Randomized run against the model.
    for (int n = 0; n < 1500; n++) begin
      b1.enable    = ($urandom_range(0, 19) != 0);
      b1.stop      = ($urandom_range(0, 59) == 0);
      b1.clear     = ($urandom_range(0, 7) == 0);
      b1.load      = ($urandom_range(0, 5) == 0);
      b1.period_in = W'($urandom_range(0, 12));
      set_duties($urandom_range(0, 14), $urandom_range(0, 14),
                 $urandom_range(0, 14), $urandom_range(0, 14));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
